sd_cmd_arbiter: RTL

SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

---
 rtl/sd_cmd_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: round-robin host/data arbitration in front of the SD command engine.
// Optional response timeout is compiled in with SD_CMD_ARB_TIMEOUT_EN.
module sd_cmd_arbiter #(
    parameter int TO_WIDTH = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                soft_rst,
    input  logic                req_h,
    input  logic [15:0]         cmd_h,
    input  logic [31:0]         arg_h,
    input  logic                req_d,
    input  logic [15:0]         cmd_d,
    input  logic [31:0]         arg_d,
    input  logic                cmd_busy,
    input  logic                cmd_done,
    input  logic [TO_WIDTH-1:0] time_out_val,
    output logic                new_cmd,
    output logic [15:0]         cmd_setting_o,
    output logic [31:0]         argument_o,
    output logic                gnt_h,
    output logic                gnt_d,
    output logic                done_h,
    output logic                done_d,
    output logic                arb_busy,
    output logic                to_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t state;
    logic owner, last_d, pick_d, grant, expire;
    assign grant    = (req_h | req_d) & ~cmd_busy;
    // data wins when alone, or on a tie when the host was granted last
    assign pick_d   = req_d & ~(req_h & last_d);
    assign arb_busy = state != IDLE;
`ifdef SD_CMD_ARB_TIMEOUT_EN
    logic [TO_WIDTH-1:0] cnt;
    always_ff @(posedge wb_clk_i or negedge wb_rst_i)
        if (!wb_rst_i) cnt <= '0;
        else cnt <= (soft_rst || state != WAIT_DONE) ? '0 : cnt + TO_WIDTH'(1);
    assign expire = (time_out_val != '0) && (cnt == time_out_val - TO_WIDTH'(1));
`else
    logic unused_tov;
    assign unused_tov = ^time_out_val;
    assign expire     = 1'b0;
`endif
    always_ff @(posedge wb_clk_i or negedge wb_rst_i)
        if (!wb_rst_i) begin
            state         <= IDLE;
            new_cmd       <= 1'b0;
            gnt_h         <= 1'b0;
            gnt_d         <= 1'b0;
            done_h        <= 1'b0;
            done_d        <= 1'b0;
            to_err        <= 1'b0;
            cmd_setting_o <= '0;
            argument_o    <= '0;
            owner         <= 1'b0;
            last_d        <= 1'b1;
        end else begin
            new_cmd <= 1'b0;
            gnt_h   <= 1'b0;
            gnt_d   <= 1'b0;
            done_h  <= 1'b0;
            done_d  <= 1'b0;
            to_err  <= 1'b0;
            if (soft_rst) state <= IDLE;
            else
                case (state)
                    IDLE: if (grant) begin
                        cmd_setting_o <= pick_d ? cmd_d : cmd_h;
                        argument_o    <= pick_d ? arg_d : arg_h;
                        gnt_h         <= ~pick_d;
                        gnt_d         <= pick_d;
                        owner         <= pick_d;
                        last_d        <= pick_d;
                        state         <= ISSUE;
                    end
                    ISSUE: begin
                        new_cmd <= 1'b1;
                        state   <= WAIT_DONE;
                    end
                    WAIT_DONE: if (cmd_done || expire) begin
                        done_h <= ~owner;
                        done_d <= owner;
                        to_err <= ~cmd_done;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule
